// File: rtl/booth_operand_feeder.sv
// Operand feeder for the sequential Booth multiplier: buffers up to two {M,Q}
// pairs, sequences clear/start/load of each job, and reports completion or timeout.
module booth_operand_feeder #(
  parameter int N       = 16,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_m,
  input  logic [N-1:0]    in_q,
  output logic            mul_clr,
  output logic            mul_start,
  output logic [N-1:0]    mul_data,
  input  logic            mul_done,
  output logic            busy,
  output logic            job_done,
  output logic            job_err,
  output logic [ID_W-1:0] job_id,
  output logic            timeout_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, RSTM, START, LOADM, LOADQ, WAIT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0][N-1:0]   fifo_m_q, fifo_m_d;
  logic [1:0][N-1:0]   fifo_q_q, fifo_q_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [N-1:0]        jm_q, jm_d;
  logic [N-1:0]        jq_q, jq_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic                err_q, err_d;
  logic                terr_q, terr_d;
  logic [ID_W-1:0]     tag_q, tag_d;
  logic                push, pop;

  assign in_ready = !rst && (count_q < 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (count_q != 2'd0);

  always_comb begin
    state_d  = state_q;
    fifo_m_d = fifo_m_q;
    fifo_q_d = fifo_q_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    jm_d     = jm_q;
    jq_d     = jq_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    terr_d   = terr_q;
    tag_d    = tag_q;

    if (push) begin
      fifo_m_d[wr_ptr_q] = in_m;
      fifo_q_d[wr_ptr_q] = in_q;
      wr_ptr_d           = ~wr_ptr_q;
    end
    if (pop) begin
      jm_d     = fifo_m_q[rd_ptr_q];
      jq_d     = fifo_q_q[rd_ptr_q];
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = RSTM;
          err_d   = 1'b0;
        end
      end
      RSTM:  state_d = START;
      START: state_d = LOADM;
      LOADM: state_d = LOADQ;
      LOADQ: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      // A done arriving on the last permitted cycle still counts as success.
      WAIT: begin
        if (mul_done) begin
          state_d = DONE;
        end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          terr_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      DONE: begin
        tag_d   = tag_q + ID_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fifo_m_q <= '0;
      fifo_q_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      jm_q     <= '0;
      jq_q     <= '0;
      wcnt_q   <= '0;
      err_q    <= 1'b0;
      terr_q   <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      fifo_m_q <= fifo_m_d;
      fifo_q_q <= fifo_q_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      jm_q     <= jm_d;
      jq_q     <= jq_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      terr_q   <= terr_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    mul_data = '0;
    case (state_q)
      RSTM, START, LOADM: mul_data = jm_q;
      LOADQ, WAIT:        mul_data = jq_q;
      default:            mul_data = '0;
    endcase
  end

  assign mul_clr     = (state_q == RSTM);
  assign mul_start   = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign job_done    = (state_q == DONE);
  assign job_err     = (state_q == DONE) && err_q;
  assign job_id      = (state_q == DONE) ? tag_q : '0;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_booth_operand_feeder.sv
// Scoreboard bench for booth_operand_feeder: a multiplier model drives mul_done,
// a monitor pops expected jobs on job_done and compares tag, error, bus data, latency.
module tb_booth_operand_feeder;

  localparam int N       = 16;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_m;
  logic [N-1:0]    in_q;
  logic            mul_clr;
  logic            mul_start;
  logic [N-1:0]    mul_data;
  logic            mul_done;
  logic            busy;
  logic            job_done;
  logic            job_err;
  logic [ID_W-1:0] job_id;
  logic            timeout_err;

  booth_operand_feeder #(.N(N), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
    .mul_clr(mul_clr), .mul_start(mul_start), .mul_data(mul_data), .mul_done(mul_done),
    .busy(busy), .job_done(job_done), .job_err(job_err), .job_id(job_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    m;
    logic [N-1:0]    q;
    logic [ID_W-1:0] id;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   delay_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int exp_tag = 0;
  int last_accept = 0;
  int last_id = -1;
  int phase = 0;
  int cur_delay = -1;
  int wcnt = 0;
  int clr_cycle = -10;
  int start_cycle = 0;
  int loadq_cycle = 0;
  int done_cycle = 0;
  logic [N-1:0] cap_m0, cap_m1, cap_q;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Offers one pair and returns at the negedge after the accepting edge.
  // delay < 0 means the multiplier model never raises mul_done for this job.
  task automatic apply_stimulus(input logic [N-1:0] m, input logic [N-1:0] q, input int delay);
    int   n;
    exp_t e;
    n = 0;
    in_m = m;
    in_q = q;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_output("send_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.m = m;
    e.q = q;
    e.id = exp_tag[ID_W-1:0];
    e.err = (delay < 0);
    exp_q.push_back(e);
    delay_q.push_back(delay);
    exp_tag = (exp_tag + 1) % (1 << ID_W);
    last_accept = cyc + 1;
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, {31'd0, (n < budget)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_output({pfx, "_in_ready"},    {31'd0, in_ready},    32'd0);
    check_output({pfx, "_mul_clr"},     {31'd0, mul_clr},     32'd0);
    check_output({pfx, "_mul_start"},   {31'd0, mul_start},   32'd0);
    check_output({pfx, "_mul_data"},    {16'd0, mul_data},    32'd0);
    check_output({pfx, "_busy"},        {31'd0, busy},        32'd0);
    check_output({pfx, "_job_done"},    {31'd0, job_done},    32'd0);
    check_output({pfx, "_job_err"},     {31'd0, job_err},     32'd0);
    check_output({pfx, "_job_id"},      {28'd0, job_id},      32'd0);
    check_output({pfx, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  // Multiplier model: tracks clr/start/load cycles, captures the bus, raises done.
  initial begin
    mul_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mul_done = 1'b0;
        phase = 0;
      end else if (mul_clr) begin
        mul_done = 1'b0;
        phase = 1;
        clr_cycle = cyc;
      end else if (mul_start) begin
        check_output("clr_before_start", {31'd0, (phase == 1 && clr_cycle == cyc - 1)}, 32'd1);
        start_cycle = cyc;
        cap_m0 = mul_data;
        cur_delay = (delay_q.size() != 0) ? delay_q.pop_front() : -1;
        phase = 2;
      end else if (phase == 2) begin
        cap_m1 = mul_data;
        phase = 3;
      end else if (phase == 3) begin
        cap_q = mul_data;
        loadq_cycle = cyc;
        wcnt = 0;
        phase = 4;
      end else if (phase == 4) begin
        if (cur_delay >= 0 && wcnt == cur_delay) begin
          mul_done = 1'b1;
          done_cycle = cyc;
          phase = 5;
        end
        wcnt++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (job_done) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_job_done", {31'd0, job_done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("job_id",      {28'd0, job_id},   {28'd0, e.id});
          check_output("job_err",     {31'd0, job_err},  {31'd0, e.err});
          check_output("bus_idle",    {16'd0, mul_data}, 32'd0);
          check_output("bus_m_start", {16'd0, cap_m0},   {16'd0, e.m});
          check_output("bus_m_loadm", {16'd0, cap_m1},   {16'd0, e.m});
          check_output("bus_q",       {16'd0, cap_q},    {16'd0, e.q});
          if (e.err) begin
            check_output("timeout_latency", cyc, loadq_cycle + TIMEOUT + 1);
            check_output("timeout_err_set", {31'd0, timeout_err}, 32'd1);
          end else begin
            check_output("done_latency", cyc, done_cycle + 1);
          end
          last_id = int'(job_id);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] global time limit");
  end

  initial begin
    int t;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_m = '0;
    in_q = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_por", {31'd0, in_ready}, 32'd1);

    // Single job M=3, Q=-5, done 40 WAIT cycles in
    apply_stimulus(16'h0003, 16'hFFFB, 40);
    t = last_accept;
    in_valid = 1'b0;
    drain("drain_single", 300);
    check_output("clr_latency",   clr_cycle,   t + 1);
    check_output("start_latency", start_cycle, t + 2);
    check_output("loadq_latency", loadq_cycle, t + 4);

    // Three pairs back to back; the second push coincides with the first pop
    apply_stimulus(16'h0011, 16'h0022, 3);
    check_output("ready_after_first", {31'd0, in_ready}, 32'd1);
    apply_stimulus(16'h8000, 16'h7FFF, 4);
    check_output("ready_push_pop", {31'd0, in_ready}, 32'd1);
    check_output("busy_push_pop",  {31'd0, busy},     32'd1);
    apply_stimulus(16'h1234, 16'hFEDC, 2);
    check_output("ready_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    drain("drain_three", 400);

    // Timeout then a normal job
    apply_stimulus(16'h0005, 16'h0006, -1);
    apply_stimulus(16'h0007, 16'hFFF9, 5);
    in_valid = 1'b0;
    drain("drain_timeout", 400);
    check_output("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset during WAIT with a second pair queued
    apply_stimulus(16'h0101, 16'h0202, -1);
    apply_stimulus(16'h0303, 16'h0404, -1);
    in_valid = 1'b0;
    n = 0;
    while (phase != 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("reach_wait", {31'd0, (phase == 4)}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_q.delete();
    delay_q.delete();
    exp_tag = 0;
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_rst", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("fifo_empty_after_rst", {31'd0, busy}, 32'd0);
    end

    // Seventeen jobs; tag wraps back to 0 on the last
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(16'(i * 3 + 1), 16'(16'hFF00 + i), 1);
    end
    in_valid = 1'b0;
    drain("drain_wrap", 3000);
    check_output("wrap_last_id", last_id, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
